// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Brief    : Shared register-file constants and the writeback queue entry type.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int GR_ADDR_W = 5;
  localparam int GR_DATA_W = 32;
  localparam logic [GR_ADDR_W-1:0] GR_ZERO = 5'd0;

  // One pending register-file write; valid marks occupied queue slots.
  typedef struct packed {
    logic                 valid;
    logic [GR_ADDR_W-1:0] addr;
    logic [GR_DATA_W-1:0] data;
  } wb_entry_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/wbq_fwd_search.sv
`default_nettype none
// ============================================================================
// Module   : wbq_fwd_search
// Brief    : Combinational youngest-first address match over the writeback
//            queue entries. The tail pointer marks the next free slot, so the
//            youngest entry sits at tail-1 and the oldest at tail.
// Revision : 1.0 - initial release
// ============================================================================
module wbq_fwd_search
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wb_entry_t                    entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]     tail,
  input  logic [GR_ADDR_W-1:0]         fwd_addr,
  output logic                         hit,
  output logic [GR_DATA_W-1:0]         data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] w_idx;

  // Walk oldest to youngest so the youngest match is the last one to win;
  // GR0 never forwards because it is hardwired to zero.
  always_comb begin
    hit   = 1'b0;
    data  = '0;
    w_idx = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      w_idx = tail - PTR_W'(k);
      if (entries[w_idx].valid && (entries[w_idx].addr == fwd_addr)) begin
        hit  = 1'b1;
        data = entries[w_idx].data;
      end
    end
    if (fwd_addr == GR_ZERO) begin
      hit  = 1'b0;
      data = '0;
    end
  end

endmodule : wbq_fwd_search
`default_nettype wire

// File: rtl/wb_write_queue.sv
`default_nettype none
// ============================================================================
// Module   : wb_write_queue
// Brief    : Writeback request FIFO feeding the 5-to-32 register-file write
//            decoder. Accepts GR writes via valid/ready, drains one per cycle
//            onto decoder D/E and the write-data bus, and offers a
//            youngest-match forwarding lookup over pending writes.
//            Optional: define WBQ_COALESCE_EN to merge a write into the
//            youngest entry when it targets the same GR.
// Revision : 1.0 - initial release
// ============================================================================
module wb_write_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     out_hold,
  output logic                     out_e,
  output logic [ADDR_W-1:0]        out_d,
  output logic [DATA_W-1:0]        out_data,
  input  logic [ADDR_W-1:0]        fwd_addr,
  output logic                     fwd_hit,
  output logic [DATA_W-1:0]        fwd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_full_count = CNT_W'(DEPTH);

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_not_empty;
  logic w_push_hs;
  logic w_pop;
  logic w_alloc;
  logic w_coalesce;

  assign w_not_empty = (r_count != '0);
  assign in_ready    = (r_count != c_full_count);
  assign w_push_hs   = in_valid & in_ready;
  assign out_e       = w_not_empty & ~out_hold;
  assign w_pop       = out_e;

`ifdef WBQ_COALESCE_EN
  logic [PTR_W-1:0] w_young;
  assign w_young = r_wr_ptr - 1'b1;
  // Merge into the youngest entry unless it is the lone head leaving this cycle.
  assign w_coalesce = w_push_hs & (in_addr != GR_ZERO) & w_not_empty &
                      (r_mem[w_young].addr == in_addr) &
                      ~(w_pop & (r_count == CNT_W'(1)));
`else
  assign w_coalesce = 1'b0;
`endif

  // GR0 requests are handshaken but never occupy a slot.
  assign w_alloc = w_push_hs & (in_addr != GR_ZERO) & ~w_coalesce;

  // Queue storage, pointers and occupancy; reset discards every pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_pop) begin
        r_mem[r_rd_ptr].valid <= 1'b0;
        r_rd_ptr              <= r_rd_ptr + 1'b1;
      end
      if (w_alloc) begin
        r_mem[r_wr_ptr] <= {1'b1, in_addr, in_data};
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
`ifdef WBQ_COALESCE_EN
      if (w_coalesce) begin
        r_mem[w_young].data <= in_data;
      end
`endif
      r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_pop);
    end
  end

  // Head entry drives the decoder; forced to zero while the queue is empty.
  always_comb begin
    out_d    = '0;
    out_data = '0;
    if (w_not_empty) begin
      out_d    = r_mem[r_rd_ptr].addr;
      out_data = r_mem[r_rd_ptr].data;
    end
  end

  assign count = r_count;

  wbq_fwd_search #(
    .DEPTH (DEPTH)
  ) u_fwd_search (
    .entries  (r_mem),
    .tail     (r_wr_ptr),
    .fwd_addr (fwd_addr),
    .hit      (fwd_hit),
    .data     (fwd_data)
  );

endmodule : wb_write_queue
`default_nettype wire

// File: tb/tb_wb_write_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_write_queue
// Brief    : Self-checking bench for wb_write_queue. Accepted writes are
//            pushed to a scoreboard; a negedge monitor pops and compares
//            every register-file write the queue issues.
//            Expectations follow WBQ_COALESCE_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_write_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        out_hold;
  logic        out_e;
  logic [4:0]  out_d;
  logic [31:0] out_data;
  logic [4:0]  fwd_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [2:0]  count;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t model[$];
  wr_t mon_e;
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  wb_write_queue #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .out_hold (out_hold),
    .out_e    (out_e),
    .out_d    (out_d),
    .out_data (out_data),
    .fwd_addr (fwd_addr),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data),
    .count    (count)
  );

  // Every issued write must be the oldest outstanding accepted write.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_e === 1'b1) begin
      checks++;
      if (model.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got d=%0d data=%h, expected no write", out_d, out_data);
      end else begin
        mon_e = model.pop_front();
        if (out_d !== mon_e.addr || out_data !== mon_e.data) begin
          errors++;
          $display("FAIL write_order got d=%0d data=%h, expected d=%0d data=%h",
                   out_d, out_data, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  // Called at posedge+1; drives one request for one cycle, returns at posedge+1.
  task automatic do_push(input logic [4:0] a, input logic [31:0] d);
    bit exp_ready;
    bit pop_now;
    in_valid  = 1'b1;
    in_addr   = a;
    in_data   = d;
    exp_ready = (model.size() != DEPTH);
    pop_now   = (model.size() != 0) && !out_hold;
    if (exp_ready && a != 5'd0) begin
`ifdef WBQ_COALESCE_EN
      if (model.size() != 0 && model[$].addr == a && !(pop_now && model.size() == 1))
        model[$].data = d;
      else
        model.push_back('{addr: a, data: d});
`else
      model.push_back('{addr: a, data: d});
`endif
    end
    @(negedge clk);
    checks++;
    if (in_ready !== exp_ready) begin
      errors++;
      $display("FAIL in_ready addr=%0d got %b expected %b (pop_now=%b)", a, in_ready, exp_ready, pop_now);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain();
    int n = 0;
    in_valid = 1'b0;
    while (model.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (model.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending, expected 0", model.size());
    end
    @(negedge clk);
    checks++;
    if (count !== 3'd0 || out_e !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty got count=%0d out_e=%b, expected 0/0", count, out_e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
    out_hold = 1'b0; fwd_addr = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_e !== 1'b0 || out_d !== 5'd0 || out_data !== 32'd0 || count !== 3'd0) begin
      errors++;
      $display("FAIL reset_outputs got e=%b d=%0d data=%h count=%0d, expected all 0", out_e, out_d, out_data, count);
    end
    fwd_addr = 5'd3;
    #1;
    checks++;
    if (fwd_hit !== 1'b0 || fwd_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_fwd got hit=%b data=%h, expected 0/0", fwd_hit, fwd_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || count !== 3'd0) begin
      errors++;
      $display("FAIL reset_ready got ready=%b count=%0d, expected 1/0", in_ready, count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    out_hold = 1'b0;
    do_push(5'd5, 32'hDEADBEEF);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_e !== 1'b1 || out_d !== 5'd5 || out_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_latency got e=%b d=%0d data=%h, expected 1/5/deadbeef", out_e, out_d, out_data);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (count !== 3'd0 || out_e !== 1'b0) begin
      errors++;
      $display("FAIL single_after got count=%0d e=%b, expected 0/0", count, out_e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fill_backpressure();
    out_hold = 1'b1;
    for (int a = 1; a <= 4; a++) do_push(5'(a), 32'h100 + a);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_full got count=%0d ready=%b, expected 4/0", count, in_ready);
    end
    @(posedge clk); #1;
    do_push(5'd9, 32'h999);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (count !== 3'd4) begin
      errors++;
      $display("FAIL fill_reject got count=%0d, expected 4", count);
    end
    @(posedge clk); #1;
    out_hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_e !== 1'b1 || out_d !== 5'(i)) begin
        errors++;
        $display("FAIL drain_seq step %0d got e=%b d=%0d, expected 1/%0d", i, out_e, out_d, i);
      end
      if (i == 1) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL full_pop_ready got %b, expected 0", in_ready);
        end
      end
      @(posedge clk); #1;
    end
    wait_drain();
  endtask

  task automatic test_gr0_drop();
    out_hold = 1'b0;
    do_push(5'd0, 32'h12345678);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (count !== 3'd0 || out_e !== 1'b0) begin
      errors++;
      $display("FAIL gr0_drop got count=%0d e=%b, expected 0/0", count, out_e);
    end
    @(posedge clk); #1;
    idle(3);
  endtask

  task automatic test_forwarding();
    out_hold = 1'b1;
    fwd_addr = 5'd7;
    do_push(5'd7, 32'h0000AAAA);
    // The entry being pushed this cycle must not yet be visible.
    in_valid = 1'b1; in_addr = 5'd7; in_data = 32'h0000BBBB;
    #1;
    checks++;
    if (fwd_hit !== 1'b1 || fwd_data !== 32'h0000AAAA) begin
      errors++;
      $display("FAIL fwd_push_invisible got hit=%b data=%h, expected 1/0000aaaa", fwd_hit, fwd_data);
    end
    #1;
    do_push(5'd7, 32'h0000BBBB);  // re-drives same request; cycle counted once
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (fwd_hit !== 1'b1 || fwd_data !== 32'h0000BBBB) begin
      errors++;
      $display("FAIL fwd_youngest got hit=%b data=%h, expected 1/0000bbbb", fwd_hit, fwd_data);
    end
    checks++;
`ifdef WBQ_COALESCE_EN
    if (count !== 3'd1) begin
      errors++;
      $display("FAIL coalesce_count got %0d, expected 1", count);
    end
`else
    if (count !== 3'd2) begin
      errors++;
      $display("FAIL fwd_count got %0d, expected 2", count);
    end
`endif
    fwd_addr = 5'd8;
    #1;
    checks++;
    if (fwd_hit !== 1'b0 || fwd_data !== 32'd0) begin
      errors++;
      $display("FAIL fwd_miss got hit=%b data=%h, expected 0/0", fwd_hit, fwd_data);
    end
    fwd_addr = 5'd0;
    #1;
    checks++;
    if (fwd_hit !== 1'b0) begin
      errors++;
      $display("FAIL fwd_gr0 got hit=%b, expected 0", fwd_hit);
    end
    fwd_addr = 5'd7;
    @(posedge clk); #1;
    out_hold = 1'b0;
    @(negedge clk);
    checks++;
    if (out_e !== 1'b1 || fwd_hit !== 1'b1 || fwd_data !== 32'h0000BBBB) begin
      errors++;
      $display("FAIL fwd_while_pop got e=%b hit=%b data=%h, expected 1/1/0000bbbb", out_e, fwd_hit, fwd_data);
    end
    @(posedge clk); #1;
    wait_drain();
  endtask

  task automatic test_async_reset();
    out_hold = 1'b1;
    do_push(5'd1, 32'h11);
    do_push(5'd2, 32'h22);
    do_push(5'd3, 32'h33);
    in_valid = 1'b0;
    out_hold = 1'b0;
    @(negedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    model.delete();
    fwd_addr = 5'd3;
    #1;
    checks++;
    if (out_e !== 1'b0 || count !== 3'd0 || out_d !== 5'd0 || fwd_hit !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got e=%b count=%0d d=%0d hit=%b, expected 0/0/0/0", out_e, count, out_d, fwd_hit);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(5);
    @(negedge clk);
    checks++;
    if (count !== 3'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset got count=%0d ready=%b, expected 0/1", count, in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    out_hold = 1'b0;
    for (int i = 0; i < 6; i++) begin
      do_push(5'(10 + i), $urandom);
      if (i > 0) begin
        checks++;
        if (count !== 3'd1) begin
          errors++;
          $display("FAIL b2b_count step %0d got %0d, expected 1", i, count);
        end
      end
    end
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_fill_backpressure();
    test_gr0_drop();
    test_forwarding();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_wb_write_queue
`default_nettype wire
